// File: rtl/game_start_ctrl.sv
// Game session controller: starts play on the first qualifying button press,
// ends it on game_over, then blocks restarts for HOLDOFF cycles.
module game_start_ctrl #(
  parameter int unsigned N       = 4,
  parameter int unsigned HOLDOFF = 16,
  parameter int unsigned EDGE    = 1,
  parameter int unsigned GW      = 8,
  localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  press,
  input  logic          game_over,
  output logic          active,
  output logic          over,
  output logic          ready,
  output logic          start,
  output logic [IW-1:0] first_id,
  output logic [GW-1:0] games
);

  localparam int unsigned CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, OVER} state_t;

  state_t        state;
  logic [N-1:0]  press_q;
  logic [N-1:0]  q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] low_id;
  logic          hold_done;
  logic          launch;

  // Qualifying presses: rising edges, or raw levels in legacy mode.
  always_comb begin
    q = (EDGE != 0) ? (press & ~press_q) : press;
  end

  // Lowest qualifying index wins when several buttons fire together.
  always_comb begin
    low_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (q[i]) low_id = IW'(i);
    end
  end

  always_comb begin
    hold_done = (cnt == CW'(HOLDOFF));
    ready     = (state == IDLE) || ((state == OVER) && hold_done);
    launch    = ready && (|q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      active   <= 1'b0;
      over     <= 1'b0;
      start    <= 1'b0;
      first_id <= '0;
      games    <= '0;
      cnt      <= '0;
      press_q  <= '1;
    end else begin
      press_q <= press;
      start   <= 1'b0;
      if (launch) begin
        state    <= ACTIVE;
        active   <= 1'b1;
        over     <= 1'b0;
        start    <= 1'b1;
        first_id <= low_id;
        games    <= games + GW'(1);
      end else begin
        case (state)
          ACTIVE: begin
            if (game_over) begin
              state  <= OVER;
              active <= 1'b0;
              over   <= 1'b1;
              cnt    <= '0;
            end
          end
          OVER: begin
            if (!hold_done) cnt <= cnt + CW'(1);
          end
          IDLE: ;
          default: begin
            state  <= IDLE;
            active <= 1'b0;
            over   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_start_ctrl.sv
// Scoreboard bench for game_start_ctrl: two configurations share one stimulus
// stream and are checked against a cycle-level reference model.
module tb_game_start_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] press = 4'b0;
  logic       game_over = 1'b0;

  logic       a0, o0, r0, s0;
  logic [1:0] f0;
  logic [7:0] g0;
  logic       a1, o1, r1, s1;
  logic [1:0] f1;
  logic [1:0] g1;

  always #5 clk = ~clk;

  game_start_ctrl #(.N(4), .HOLDOFF(16), .EDGE(1), .GW(8)) u0 (
    .clk(clk), .reset(reset), .press(press), .game_over(game_over),
    .active(a0), .over(o0), .ready(r0), .start(s0), .first_id(f0), .games(g0)
  );

  game_start_ctrl #(.N(4), .HOLDOFF(0), .EDGE(0), .GW(2)) u1 (
    .clk(clk), .reset(reset), .press(press), .game_over(game_over),
    .active(a1), .over(o1), .ready(r1), .start(s1), .first_id(f1), .games(g1)
  );

  // Model: mode 0 idle, 1 playing, 2 game over; since = cycles spent over.
  typedef struct {
    int         mode;
    int         since;
    logic [3:0] prev;
    int         first;
    int         games;
    bit         start;
  } mdl_t;

  typedef struct {
    int active, over, ready, start, first, games;
  } exp_t;

  typedef struct {
    int first, games;
  } ev_t;

  mdl_t m0, m1;
  exp_t eq0[$], eq1[$];
  ev_t  sq0[$], sq1[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic mdl_t step(mdl_t m, logic [3:0] p, logic go, logic rst,
                                int hold, bit edg, int gmod);
    logic [3:0] qual;
    bit         can_start;
    if (rst) begin
      m.mode = 0; m.since = 0; m.prev = 4'hF; m.first = 0; m.games = 0; m.start = 0;
      return m;
    end
    qual      = edg ? (p & ~m.prev) : p;
    m.prev    = p;
    m.start   = 0;
    can_start = (m.mode == 0) || (m.mode == 2 && m.since >= hold);
    if (can_start && qual != 4'b0) begin
      m.mode  = 1;
      m.start = 1;
      m.games = (m.games + 1) % gmod;
      for (int i = 3; i >= 0; i--) if (qual[i]) m.first = i;
    end else if (m.mode == 1 && go) begin
      m.mode  = 2;
      m.since = 0;
    end else if (m.mode == 2) begin
      m.since++;
    end
    return m;
  endfunction

  function automatic exp_t expect_of(mdl_t m, int hold);
    exp_t e;
    e.active = (m.mode == 1) ? 1 : 0;
    e.over   = (m.mode == 2) ? 1 : 0;
    e.ready  = (m.mode == 0 || (m.mode == 2 && m.since >= hold)) ? 1 : 0;
    e.start  = m.start ? 1 : 0;
    e.first  = m.first;
    e.games  = m.games;
    return e;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; the model advances on the same edge as the DUTs.
  task automatic cyc(logic r, logic [3:0] p, logic g);
    ev_t ev;
    @(negedge clk);
    reset = r; press = p; game_over = g;
    @(posedge clk);
    m0 = step(m0, p, g, r, 16, 1'b1, 256);
    m1 = step(m1, p, g, r, 0, 1'b0, 4);
    eq0.push_back(expect_of(m0, 16));
    eq1.push_back(expect_of(m1, 0));
    if (m0.start) begin ev.first = m0.first; ev.games = m0.games; sq0.push_back(ev); end
    if (m1.start) begin ev.first = m1.first; ev.games = m1.games; sq1.push_back(ev); end
  endtask

  // Monitor: compares the status presented each cycle and every start event.
  always @(negedge clk) begin
    exp_t e;
    ev_t  ev;
    if (eq0.size() > 0) begin
      e = eq0.pop_front();
      chk("u0.active", int'(a0), e.active);
      chk("u0.over", int'(o0), e.over);
      chk("u0.ready", int'(r0), e.ready);
      chk("u0.start", int'(s0), e.start);
      chk("u0.first_id", int'(f0), e.first);
      chk("u0.games", int'(g0), e.games);
    end
    if (eq1.size() > 0) begin
      e = eq1.pop_front();
      chk("u1.active", int'(a1), e.active);
      chk("u1.over", int'(o1), e.over);
      chk("u1.ready", int'(r1), e.ready);
      chk("u1.start", int'(s1), e.start);
      chk("u1.first_id", int'(f1), e.first);
      chk("u1.games", int'(g1), e.games);
    end
    if (s0) begin
      if (sq0.size() == 0) chk("u0.unexpected_start", 1, 0);
      else begin
        ev = sq0.pop_front();
        chk("u0.start_first_id", int'(f0), ev.first);
        chk("u0.start_games", int'(g0), ev.games);
      end
    end
    if (s1) begin
      if (sq1.size() == 0) chk("u1.unexpected_start", 1, 0);
      else begin
        ev = sq1.pop_front();
        chk("u1.start_first_id", int'(f1), ev.first);
        chk("u1.start_games", int'(g1), ev.games);
      end
    end
  end

  initial begin
    logic [3:0] p;
    logic       g, r;

    // T1: button held through reset must be released before it counts
    cyc(1'b1, 4'b0001, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0);
    repeat (3) cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0);
    repeat (2) cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1);
    repeat (20) cyc(1'b0, 4'b0000, 1'b0);

    // T2: two buttons rise together from idle
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1010, 1'b0);

    // T3: game_over and a new press in the same cycle
    cyc(1'b0, 4'b0100, 1'b1);

    // T4: presses inside holdoff are dropped; press at cycle 20 restarts
    for (int i = 0; i < 26; i++) begin
      p = (i == 5 || i == 15 || i == 20) ? 4'b0001 : 4'b0000;
      cyc(1'b0, p, 1'b0);
    end

    // T5: level press held through game_over
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b0, 4'b0001, 1'b1);
    cyc(1'b0, 4'b0001, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);

    // T6: reset mid-holdoff, then enough starts to wrap a 2-bit counter
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0010, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1);
    repeat (7) cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    repeat (5) begin
      cyc(1'b0, 4'b0001, 1'b0);
      cyc(1'b0, 4'b0000, 1'b1);
      repeat (17) cyc(1'b0, 4'b0000, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      g = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 299) == 0);
      cyc(r, p, g);
    end
    repeat (3) cyc(1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    chk("u0.pending_starts", sq0.size(), 0);
    chk("u1.pending_starts", sq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
